mc_ctrl: RTL

- Multi-cycle main controller for the snake CPU datapath.
- Sequences each MIPS-subset instruction through fetch, decode, execute, memory and writeback states.
- Drives the write enables of the datapath registers, including the PC register's CE (pc_ce) and the IR register's CE (ir_ce), plus mux selects and ALU op.
- Stalls on a memory ready handshake; a watchdog flags memory that never responds.

---
 rtl/mc_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and ALU op, with a memory watchdog.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_ce,
    output logic       ir_ce,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_fault
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
        S_WBL = 4'd4,  S_MWR = 4'd5,  S_EXR = 4'd6,  S_WBR = 4'd7,
        S_BR  = 4'd8,  S_JMP = 4'd9,  S_EXI = 4'd10, S_WBI = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_FN  = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            fault_q, fault_d;

    logic pc_ce_en, ir_ce_en, mem_wr_en, reg_wr_en, done_en, illegal_en;
    logic mem_wait;

    always_comb begin
        state_d    = state_q;
        wd_d       = '0;
        fault_d    = fault_q;
        pc_ce_en   = 1'b0;
        ir_ce_en   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr_en  = 1'b0;
        iord       = 1'b0;
        reg_wr_en  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_src     = 2'b00;
        done_en    = 1'b0;
        illegal_en = 1'b0;
        mem_wait   = 1'b0;

        case (state_q)
            S_IF: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                mem_wait  = ~mem_ready;
                if (mem_ready) begin
                    pc_ce_en = 1'b1;
                    ir_ce_en = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                // Precompute branch target into ALUOut while decoding.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R:                             state_d = S_EXR;
                    OP_LW, OP_SW:                     state_d = S_MA;
                    OP_BEQ, OP_BNE:                   state_d = S_BR;
                    OP_J:                             state_d = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
                    default: begin
                        illegal_en = 1'b1;
                        state_d    = S_IF;
                    end
                endcase
            end
            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_rd   = 1'b1;
                iord     = 1'b1;
                mem_wait = ~mem_ready;
                if (mem_ready) state_d = S_WBL;
            end
            S_WBL: begin
                reg_wr_en  = 1'b1;
                mem_to_reg = 1'b1;
                done_en    = 1'b1;
                state_d    = S_IF;
            end
            S_MWR: begin
                mem_wr_en = 1'b1;
                iord      = 1'b1;
                mem_wait  = ~mem_ready;
                if (mem_ready) begin
                    done_en = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FN;
                state_d   = S_WBR;
            end
            S_WBR: begin
                reg_wr_en = 1'b1;
                reg_dst   = 1'b1;
                done_en   = 1'b1;
                state_d   = S_IF;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_ce_en  = (opcode == OP_BNE) ? ~zero : zero;
                done_en   = 1'b1;
                state_d   = S_IF;
            end
            S_JMP: begin
                pc_src   = 2'b10;
                pc_ce_en = 1'b1;
                done_en  = 1'b1;
                state_d  = S_IF;
            end
            S_EXI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_WBI;
            end
            S_WBI: begin
                reg_wr_en = 1'b1;
                done_en   = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // A wait that reaches the limit abandons the instruction; mem_ready on
        // the same cycle keeps mem_wait low, so a late response still wins.
        if (mem_wait && (MEM_TIMEOUT != 0)) begin
            if (wd_q == WD_LAST) begin
                fault_d = 1'b1;
                state_d = S_IF;
            end else begin
                wd_d = wd_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decode from state, so gate enables while reset is held.
    assign pc_ce      = pc_ce_en   & ~rst;
    assign ir_ce      = ir_ce_en   & ~rst;
    assign mem_wr     = mem_wr_en  & ~rst;
    assign reg_wr     = reg_wr_en  & ~rst;
    assign instr_done = done_en    & ~rst;
    assign illegal    = illegal_en & ~rst;
    assign state      = state_q;
    assign mem_fault  = fault_q;

endmodule
